// File: rtl/bram_master_pkg.sv
// rtl/bram_master_pkg.sv - shared state encoding and default geometry for bram_master
// CLEAR only exists when BRAM_MASTER_CLEAR_EN is defined.
package bram_master_pkg;

   localparam int DEPTH_DEF  = 11;
   localparam int ADDR_W_DEF = 12;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RSP_HOLD = 2'd2
`ifdef BRAM_MASTER_CLEAR_EN
      ,
      CLEAR    = 2'd3
`endif
   } state_t;

endpackage

// File: rtl/bram_master.sv
// rtl/bram_master.sv - single-outstanding request bridge onto a 1-cycle-latency BRAM port
// Optional BRAM_MASTER_CLEAR_EN adds clr_start/clr_busy and a zero-fill sweep of all DEPTH words.
module bram_master
   import bram_master_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              axis_clk,
   input  logic              axis_rst_n,
`ifdef BRAM_MASTER_CLEAR_EN
   input  logic              clr_start,
   output logic              clr_busy,
`endif
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [3:0]        req_wstrb,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              bram_en,
   output logic [3:0]        bram_we,
   output logic [ADDR_W-1:0] bram_a,
   output logic [31:0]       bram_di,
   input  logic [31:0]       bram_do
);

   localparam logic [ADDR_W-3:0] DEPTH_W = (ADDR_W-2)'(DEPTH);

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_q;
   logic              in_range;
   logic              rd_issue, rd_oor, rd_capture;
   logic              clr_req;

   assign in_range = (req_addr[ADDR_W-1:2] < DEPTH_W);

`ifdef BRAM_MASTER_CLEAR_EN
   localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic [CNT_W-1:0] clr_cnt;
   logic             clr_last;
   assign clr_req  = clr_start;
   assign clr_last = (clr_cnt == CNT_W'(DEPTH - 1));
`else
   assign clr_req  = 1'b0;
`endif

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef BRAM_MASTER_CLEAR_EN
         clr_cnt   <= '0;
`endif
      end else begin
         state <= state_n;
         if (rd_issue) begin
            addr_q  <= req_addr;
            rsp_err <= 1'b0;
         end
         if (rd_oor) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
         end
         if (rd_capture) begin
            rsp_rdata <= bram_do;
         end
`ifdef BRAM_MASTER_CLEAR_EN
         clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      bram_en    = 1'b0;
      bram_we    = 4'h0;
      bram_a     = '0;
      bram_di    = '0;
      rd_issue   = 1'b0;
      rd_oor     = 1'b0;
      rd_capture = 1'b0;
`ifdef BRAM_MASTER_CLEAR_EN
      clr_busy   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (clr_req) begin
`ifdef BRAM_MASTER_CLEAR_EN
               state_n = CLEAR;
`endif
            end else begin
               req_ready = 1'b1;
               if (req_valid) begin
                  if (req_we) begin
                     if (in_range) begin
                        bram_en = 1'b1;
                        bram_we = req_wstrb;
                        bram_a  = req_addr;
                        bram_di = req_wdata;
                     end
                  end else if (in_range) begin
                     bram_en  = 1'b1;
                     bram_a   = req_addr;
                     rd_issue = 1'b1;
                     state_n  = RD_WAIT;
                  end else begin
                     rd_oor  = 1'b1;
                     state_n = RSP_HOLD;
                  end
               end
            end
         end
         RD_WAIT: begin
            // data for the address presented last cycle is on bram_do now
            bram_en    = 1'b1;
            bram_a     = addr_q;
            rd_capture = 1'b1;
            state_n    = RSP_HOLD;
         end
         RSP_HOLD: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_n = IDLE;
            end
         end
`ifdef BRAM_MASTER_CLEAR_EN
         CLEAR: begin
            clr_busy = 1'b1;
            bram_en  = 1'b1;
            bram_we  = 4'hF;
            bram_a   = ADDR_W'({clr_cnt, 2'b00});
            if (clr_last) begin
               state_n = IDLE;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
      // reset holds state at IDLE, so the IDLE-derived outputs must be forced low here
      if (!axis_rst_n) begin
         req_ready = 1'b0;
         bram_en   = 1'b0;
         bram_we   = 4'h0;
         bram_a    = '0;
         bram_di   = '0;
      end
   end

endmodule

// File: tb/tb_bram_master.sv
// tb/tb_bram_master.sv - directed self-checking bench for bram_master with a behavioural BRAM
// Clear-sequence steps run only when BRAM_MASTER_CLEAR_EN is defined.
module tb_bram_master;

   localparam int DEPTH = 11;

   logic        axis_clk;
   logic        axis_rst_n;
   logic        req_valid, req_ready, req_we;
   logic [3:0]  req_wstrb;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        bram_en;
   logic [3:0]  bram_we;
   logic [11:0] bram_a;
   logic [31:0] bram_di, bram_do;
`ifdef BRAM_MASTER_CLEAR_EN
   logic        clr_start, clr_busy;
`endif

   int tests = 0;
   int fails = 0;
   int en_cnt = 0;
   int en_snap;
   logic [31:0] mem [0:15] = '{default: 32'h0};

   bram_master #(.DEPTH(DEPTH), .ADDR_W(12)) dut (
      .axis_clk   (axis_clk),
      .axis_rst_n (axis_rst_n),
`ifdef BRAM_MASTER_CLEAR_EN
      .clr_start  (clr_start),
      .clr_busy   (clr_busy),
`endif
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_wstrb  (req_wstrb),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .bram_en    (bram_en),
      .bram_we    (bram_we),
      .bram_a     (bram_a),
      .bram_di    (bram_di),
      .bram_do    (bram_do)
   );

   initial axis_clk = 1'b0;
   always #5 axis_clk = ~axis_clk;

   always @(posedge axis_clk) begin
      if (bram_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bram_we[b]) mem[bram_a[5:2]][8*b +: 8] <= bram_di[8*b +: 8];
         end
         bram_do <= mem[bram_a[5:2]];
         en_cnt  <= en_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] s);
      @(negedge axis_clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = d; req_wstrb = s;
      #1;
      chk("wr_ready", req_ready, 1);
      if (addr[11:2] < DEPTH) begin
         chk("wr_en", bram_en, 1);
         chk("wr_we", bram_we, s);
         chk("wr_a", bram_a, addr);
         chk("wr_di", bram_di, d);
      end else begin
         chk("wr_oor_we", bram_we, 0);
      end
      @(posedge axis_clk); #1;
      req_valid = 1'b0; req_we = 1'b0;
      @(negedge axis_clk);
      chk("wr_no_rsp", rsp_valid, 0);
   endtask

   task automatic do_read(input logic [11:0] addr, input logic [31:0] exp_d,
                          input logic exp_e, input int hold);
      rsp_ready = (hold == 0);
      @(negedge axis_clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wstrb = 4'h0;
      #1;
      chk("rd_ready", req_ready, 1);
      chk("rd_en", bram_en, {31'b0, !exp_e});
      @(posedge axis_clk); #1;
      req_valid = 1'b0;
      if (!exp_e) begin
         @(negedge axis_clk);
         chk("rd_wait_valid", rsp_valid, 0);
         chk("rd_wait_en", bram_en, 1);
         chk("rd_wait_ready", req_ready, 0);
      end
      @(negedge axis_clk);
      chk("rd_valid", rsp_valid, 1);
      chk("rd_data", rsp_rdata, exp_d);
      chk("rd_err", rsp_err, {31'b0, exp_e});
      chk("rd_hold_ready", req_ready, 0);
      for (int i = 1; i < hold; i++) begin
         @(negedge axis_clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data", rsp_rdata, exp_d);
         chk("hold_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge axis_clk);
      chk("rd_done_valid", rsp_valid, 0);
      chk("rd_done_ready", req_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      axis_rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_wstrb = 4'h0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b1;
`ifdef BRAM_MASTER_CLEAR_EN
      clr_start = 1'b0;
`endif
      repeat (2) @(negedge axis_clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_bram_en", bram_en, 0);
      chk("rst_bram_we", bram_we, 0);
      chk("rst_bram_a", bram_a, 0);
      chk("rst_bram_di", bram_di, 0);
      @(negedge axis_clk);
      axis_rst_n = 1'b1;
      #1;
      chk("post_rst_ready", req_ready, 1);

      do_write(12'h008, 32'hDEADBEEF, 4'hF);
      do_read(12'h008, 32'hDEADBEEF, 1'b0, 0);

      do_write(12'h010, 32'h11223344, 4'hF);
      do_write(12'h010, 32'h0000AB00, 4'b0010);
      do_read(12'h010, 32'h1122AB44, 1'b0, 0);

      en_snap = en_cnt;
      do_read(12'h02C, 32'h0, 1'b1, 0);
      chk("oor_rd_no_en", en_cnt, en_snap);

      do_write(12'h02C, 32'hCAFEF00D, 4'hF);
      chk("oor_wr_mem", mem[11], 32'h0);

      do_write(12'h028, 32'h0BADF00D, 4'hF);
      do_read(12'h028, 32'h0BADF00D, 1'b0, 0);

      do_write(12'h020, 32'h5A5A1234, 4'hF);
      do_read(12'h020, 32'h5A5A1234, 1'b0, 5);

`ifdef BRAM_MASTER_CLEAR_EN
      begin
         int busy;
         for (int i = 0; i < DEPTH; i++) do_write(12'(i * 4), 32'hA000_0000 + i, 4'hF);
         @(negedge axis_clk);
         clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b1;
         req_addr = 12'h004; req_wdata = 32'h12345678; req_wstrb = 4'hF;
         #1;
         chk("clr_prio_ready", req_ready, 0);
         chk("clr_prio_en", bram_en, 0);
         @(posedge axis_clk); #1;
         clr_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
         busy = 0;
         for (int i = 0; i < 30; i++) begin
            @(negedge axis_clk);
            if (clr_busy) busy++;
         end
         chk("clr_busy_cycles", busy, DEPTH);
         for (int i = 0; i < DEPTH; i++) do_read(12'(i * 4), 32'h0, 1'b0, 0);

         for (int i = 0; i < DEPTH; i++) do_write(12'(i * 4), 32'hB000_0000 + i, 4'hF);
         @(negedge axis_clk);
         clr_start = 1'b1;
         @(posedge axis_clk); #1;
         clr_start = 1'b0;
         repeat (4) @(posedge axis_clk);
         #1;
         chk("clr4_busy", clr_busy, 1);
         chk("clr4_addr", bram_a, 12'h010);
         axis_rst_n = 1'b0;
         #1;
         chk("clr_rst_busy", clr_busy, 0);
         chk("clr_rst_en", bram_en, 0);
         chk("clr_rst_we", bram_we, 0);
         chk("clr_rst_a", bram_a, 0);
         chk("clr_rst_ready", req_ready, 0);
         chk("clr_rst_valid", rsp_valid, 0);
         @(negedge axis_clk);
         @(negedge axis_clk);
         axis_rst_n = 1'b1;
         #1;
         chk("clr_rel_ready", req_ready, 1);
         chk("clr_rel_busy", clr_busy, 0);
         @(negedge axis_clk);
         chk("clr_not_resumed", clr_busy, 0);
         for (int i = 0; i < DEPTH; i++) begin
            chk("clr_partial_mem", mem[i], (i < 4) ? 32'h0 : 32'hB000_0000 + i);
         end
         do_read(12'h018, 32'hB000_0006, 1'b0, 0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bram_master.md
BRAM_MASTER -- requirements
Module: bram_master

Interface
REQ-001 SHALL provide parameters: DEPTH, default 11, number of 32-bit words in the attached BRAM; ADDR_W, default 12, byte-address width.
REQ-002 SHALL have a single clock and an asynchronous, active-low reset: axis_clk  in  1  clock; axis_rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL provide req_valid  in  1  request offered; req_ready  out  1  request accepted when both high.
REQ-004 SHALL provide req_we  in  1  write (1) / read (0); req_wstrb  in  4  byte enables; req_addr  in  ADDR_W  byte address; req_wdata  in  32  write data.
REQ-005 SHALL provide rsp_valid  out  1  read data valid; rsp_ready  in  1  consumer accepts; rsp_rdata  out  32  read data; rsp_err  out  1  read was out of range.
REQ-006 SHALL provide clr_start  in  1  start clear; clr_busy  out  1  clear in progress (clear port pair present only with BRAM_MASTER_CLEAR_EN).
REQ-007 SHALL provide the BRAM-side ports: bram_en  out  1; bram_we  out  4; bram_a  out  ADDR_W; bram_di  out  32; bram_do  in  32 (BRAM registers the address and returns data the following cycle, gated by bram_en).

Function
REQ-008 SHALL implement FSM states IDLE, RD_WAIT, RSP_HOLD, CLEAR.
REQ-009 SHALL drive req_ready = 1 only in IDLE and only when clr_start is low.
REQ-010 SHALL, on an accepted write, drive in the same cycle bram_en=1, bram_we=req_wstrb, bram_a=req_addr, bram_di=req_wdata; remain in IDLE; produce no response.
REQ-011 SHALL suppress the BRAM access (bram_we=0) for a write whose word index (req_addr>>2) >= DEPTH; the request is still accepted.
REQ-012 SHALL, on an accepted in-range read in cycle N, drive bram_en=1, bram_we=0, bram_a=req_addr in cycle N, go to RD_WAIT, keep bram_en=1 in cycle N+1, and register bram_do at the end of N+1.
REQ-013 SHALL assert rsp_valid from cycle N+2 (RSP_HOLD), holding rsp_rdata and rsp_err stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-014 SHALL, for an out-of-range read, skip the BRAM access, go directly to RSP_HOLD, and return rsp_rdata=0 and rsp_err=1 from cycle N+1.
REQ-015 SHALL allow at most one read outstanding; no new request is accepted in RD_WAIT or RSP_HOLD.
REQ-016 SHALL drive bram_en=0, bram_we=0 in every cycle with no access; bram_a and bram_di are don't-care when bram_en=0.

Reset
REQ-017 SHALL, on axis_rst_n low, asynchronously enter IDLE and clear every output to 0: req_ready, rsp_valid, rsp_rdata, rsp_err, clr_busy, bram_en, bram_we, bram_a, bram_di.
REQ-018 SHALL, on reset during RD_WAIT, RSP_HOLD or CLEAR, abandon the operation; no response is issued and the clear is not resumed.
REQ-019 SHALL hold req_ready high in the first cycle after reset release.

Configuration
REQ-020 SHALL, with BRAM_MASTER_CLEAR_EN defined, enter CLEAR when clr_start=1 in IDLE (taking priority over a simultaneous req_valid).
REQ-021 SHALL, in CLEAR, write 32'h0 with bram_we=4'hF to byte addresses 0,4,...,4*(DEPTH-1), one word per cycle, holding clr_busy=1 for exactly DEPTH cycles, then return to IDLE.
REQ-022 SHALL ignore clr_start outside IDLE.
REQ-023 SHALL, without BRAM_MASTER_CLEAR_EN, omit the clr_start/clr_busy ports, the CLEAR state and the clear counter; req_ready then ignores clr_start.

Structure
REQ-024 SHALL place the FSM state enumeration and the default DEPTH/ADDR_W constants in the shared package bram_master_pkg.
REQ-025 SHALL be a single module with no sub-modules; the BRAM itself stays external.

Verification
REQ-026 SHALL verify: write addr 0x08, wdata 0xDEADBEEF, wstrb 4'hF, then read 0x08 with rsp_ready=1 -> rsp_valid two cycles after acceptance, rdata 0xDEADBEEF, err 0.
REQ-027 SHALL verify: wstrb 4'b0010, wdata 0x0000AB00 over word 0x11223344 -> read returns 0x1122AB44.
REQ-028 SHALL verify: read 0x2C (word 11, DEPTH 11) -> rsp_valid the next cycle, rdata 0, err 1, bram_en never asserted.
REQ-029 SHALL verify: rsp_ready held low 5 cycles -> rsp_rdata stable, req_ready low throughout, single transfer when released.
REQ-030 SHALL verify (CLEAR_EN): clr_start and req_valid high together in IDLE -> request not accepted, clr_busy high for 11 cycles, all words read back 0.
REQ-031 SHALL verify: axis_rst_n pulsed low at clear cycle 4 -> all outputs 0 immediately, IDLE after release, words 4..10 unchanged.
